// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and configurable frame format.
// Frames leave back-to-back while the FIFO holds data; tx_done pulses on the last stop cycle.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int LED_HOLD   = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 overflow,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 led
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int OCC_W        = PTR_W + 1;
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam int LED_W        = (LED_HOLD > 0) ? $clog2(LED_HOLD + 1) : 1;
    localparam logic PARITY_INIT = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0]     occ_reg, occ_next;
    logic                 full_reg, empty_reg, overflow_reg;
    logic                 push, pop;

    assign push = wr_en && !full_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + OCC_W'(1);
            2'b01:   occ_next = occ_reg - OCC_W'(1);
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            occ_reg   <= occ_next;
            full_reg  <= (occ_next == OCC_W'(FIFO_DEPTH));
            empty_reg <= (occ_next == '0);
            // A drop is judged on last cycle's full flag, even if a pop frees a slot now.
            if (wr_en && full_reg) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ---------------- Serialiser ----------------
    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic                 tx_reg, tx_next;
    logic [LED_W-1:0]     led_cnt_reg, led_cnt_next;
    logic                 bit_last, frame_end;

    assign bit_last  = (bit_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
    assign frame_end = (state_reg == ST_STOP) && bit_last && (idx_reg == IDX_W'(STOP_BITS - 1));
    assign pop       = !empty_reg && ((state_reg == ST_IDLE) || frame_end);

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_last ? '0 : bit_cnt_reg + CNT_W'(1);
        idx_next     = idx_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        case (state_reg)
            ST_IDLE: begin
                bit_cnt_next = '0;
                if (pop) begin
                    state_next  = ST_START;
                    parity_next = PARITY_INIT;
                end
            end
            ST_START: begin
                if (bit_last) begin
                    state_next = ST_DATA;
                    idx_next   = '0;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    // Parity accumulates bit by bit as the word shifts out.
                    parity_next = parity_reg ^ shift_reg[0];
                    shift_next  = shift_reg >> 1;
                    if (idx_reg == IDX_W'(DATA_BITS - 1)) begin
                        idx_next   = '0;
                        state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_last) begin
                    state_next = ST_STOP;
                    idx_next   = '0;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    if (idx_reg == IDX_W'(STOP_BITS - 1)) begin
                        idx_next = '0;
                        if (pop) begin
                            state_next  = ST_START;
                            parity_next = PARITY_INIT;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The line level is registered from the next-state view so the pin never glitches.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = parity_next;
            default:   tx_next = 1'b1;
        endcase
    end

    always_comb begin
        led_cnt_next = led_cnt_reg;
        if (frame_end) begin
            led_cnt_next = LED_W'(LED_HOLD);
        end else if (led_cnt_reg != '0) begin
            led_cnt_next = led_cnt_reg - LED_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            tx_reg      <= 1'b1;
            led_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            idx_reg     <= idx_next;
            shift_reg   <= pop ? mem[rd_ptr_reg] : shift_next;
            parity_reg  <= parity_next;
            tx_reg      <= tx_next;
            led_cnt_reg <= led_cnt_next;
        end
    end

    assign fifo_full  = full_reg;
    assign fifo_empty = empty_reg;
    assign overflow   = overflow_reg;
    assign tx         = tx_reg;
    assign tx_busy    = (state_reg != ST_IDLE);
    assign tx_done    = frame_end;
    assign led        = (led_cnt_reg != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances with different frame formats, a queue-based
// line model compared every cycle, and directed scenarios with hand-computed values.
module tb_uart_tx_fifo;
    localparam int NI   = 4;
    localparam int CLKS = 10;
    localparam int LED  = 50;

    function automatic int db_of(input int i);
        case (i)
            2:       return 7;
            default: return 8;
        endcase
    endfunction
    function automatic int par_of(input int i);
        case (i)
            1:       return 2;
            2:       return 0;
            default: return 1;
        endcase
    endfunction
    function automatic int sb_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction
    function automatic int dep_of(input int i);
        return (i == 3) ? 4 : 16;
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI-1:0] wr_en = '0;
    logic [8:0]    wr_data [NI];
    logic [NI-1:0] fifo_full, fifo_empty, overflow, tx, tx_busy, tx_done, led;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            uart_tx_fifo #(
                .CLK_FREQ  (1_000_000),
                .BAUD_RATE (100_000),
                .DATA_BITS (db_of(gi)),
                .PARITY    (par_of(gi)),
                .STOP_BITS (sb_of(gi)),
                .FIFO_DEPTH(dep_of(gi)),
                .LED_HOLD  (LED)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .wr_en     (wr_en[gi]),
                .wr_data   (wr_data[gi][db_of(gi)-1:0]),
                .fifo_full (fifo_full[gi]),
                .fifo_empty(fifo_empty[gi]),
                .overflow  (overflow[gi]),
                .tx        (tx[gi]),
                .tx_busy   (tx_busy[gi]),
                .tx_done   (tx_done[gi]),
                .led       (led[gi])
            );
        end
    endgenerate

    // Model: pending words, position inside the current frame (-1 = idle), frame bit list.
    int          q [NI][$];
    int          pos [NI];
    int          flen [NI];
    logic [15:0] frm [NI];
    int          led_m [NI];
    logic        ovf_m [NI];
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic void build_frame(input int i, input int w);
        int   n;
        logic p;
        frm[i] = '1;
        frm[i][0] = 1'b0;
        p = (par_of(i) == 2);
        for (int k = 0; k < db_of(i); k++) begin
            frm[i][1+k] = w[k];
            p = p ^ w[k];
        end
        n = 1 + db_of(i);
        if (par_of(i) != 0) begin
            frm[i][n] = p;
            n++;
        end
        flen[i] = (n + sb_of(i)) * CLKS;
    endfunction

    function automatic void model_step();
        int   sz;
        int   w;
        logic last;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                q[i].delete();
                pos[i]   = -1;
                led_m[i] = 0;
                ovf_m[i] = 1'b0;
            end else begin
                sz   = q[i].size();
                last = (pos[i] == flen[i] - 1);
                if (last) led_m[i] = LED;
                else if (led_m[i] > 0) led_m[i]--;
                if (sz > 0 && (pos[i] < 0 || last)) begin
                    w = q[i].pop_front();
                    build_frame(i, w);
                    pos[i] = 0;
                end else if (last) begin
                    pos[i] = -1;
                end else if (pos[i] >= 0) begin
                    pos[i]++;
                end
                if (wr_en[i]) begin
                    if (sz == dep_of(i)) ovf_m[i] = 1'b1;
                    else q[i].push_back(int'(wr_data[i]) & ((1 << db_of(i)) - 1));
                end
            end
        end
    endfunction

    function automatic void compare_all();
        logic [6:0] act, exp;
        logic       tx_e;
        for (int i = 0; i < NI; i++) begin
            tx_e = 1'b1;
            if (pos[i] >= 0) tx_e = frm[i][pos[i] / CLKS];
            act = {tx[i], tx_busy[i], tx_done[i], led[i], fifo_full[i], fifo_empty[i], overflow[i]};
            exp = {tx_e, (pos[i] >= 0), (pos[i] == flen[i] - 1), (led_m[i] != 0),
                   (q[i].size() == dep_of(i)), (q[i].size() == 0), ovf_m[i]};
            n_chk++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_u%0d t=%0t tx/busy/done/led/full/empty/ovf got %b expected %b",
                         i, $time, act, exp);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic expect_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int i, input int w);
        wr_en[i]   = 1'b1;
        wr_data[i] = 9'(w);
        tick();
        wr_en[i]   = 1'b0;
        $display("push u%0d data=0x%0h", i, w);
    endtask

    task automatic wait_start(input int i, input string tag);
        int t = 0;
        while (tx[i] !== 1'b0 && t < 300) begin
            tick();
            t++;
        end
        expect_eq({tag, "_start_seen"}, int'(tx[i] === 1'b0), 1);
    endtask

    // Sample every bit mid-period, then check the single done pulse and optional LED hold.
    task automatic check_frame(input int i, input int bits[12], input int nbits,
                               input string tag, input bit chk_led);
        int done_at = -1;
        int ndone   = 0;
        int c       = 0;
        wait_start(i, tag);
        for (int off = 0; off < nbits * CLKS; off++) begin
            if (off % CLKS == CLKS / 2)
                expect_eq($sformatf("%s_bit%0d", tag, off / CLKS), int'(tx[i]), bits[off / CLKS]);
            if (tx_done[i]) begin
                ndone++;
                done_at = off;
            end
            tick();
        end
        expect_eq({tag, "_done_count"}, ndone, 1);
        expect_eq({tag, "_done_offset"}, done_at, nbits * CLKS - 1);
        expect_eq({tag, "_idle_after"}, int'(tx[i]), 1);
        if (chk_led) begin
            while (led[i] && c < 200) begin
                c++;
                tick();
            end
            expect_eq({tag, "_led_cycles"}, c, LED);
        end
        $display("frame u%0d %s: %0d bits, done at offset %0d", i, tag, nbits, done_at);
    endtask

    initial begin
        int off, ndone, busy_low, empty_at, c;
        int dones [3];
        for (int i = 0; i < NI; i++) begin
            wr_data[i] = '0;
            pos[i]     = -1;
            flen[i]    = CLKS;
            frm[i]     = '1;
            led_m[i]   = 0;
            ovf_m[i]   = 1'b0;
        end

        repeat (3) tick();
        expect_eq("reset_tx", int'(tx), 'hF);
        expect_eq("reset_busy", int'(tx_busy), 0);
        expect_eq("reset_empty", int'(fifo_empty), 'hF);
        expect_eq("reset_full", int'(fifo_full), 0);
        expect_eq("reset_led", int'(led), 0);
        rst = 1'b0;
        repeat (2) tick();

        push(0, 'hA5);
        check_frame(0, '{0,1,0,1,0,0,1,0,1,0,1,1}, 11, "a5_even", 1'b1);

        push(1, 'h03);
        check_frame(1, '{0,1,1,0,0,0,0,0,0,1,1,1}, 12, "03_odd_2stop", 1'b0);

        push(2, 'h55);
        check_frame(2, '{0,1,0,1,0,1,0,1,1,1,1,1}, 9, "55_7bit_nopar", 1'b0);

        // Back-to-back: offsets counted from the first start bit.
        push(0, 'h11);
        push(0, 'h22);
        expect_eq("b2b_start_latency", int'(tx[0]), 0);
        push(0, 'h33);
        off = 1; ndone = 0; busy_low = -1; empty_at = -1;
        while (off < 400 && busy_low < 0) begin
            if (tx_done[0]) begin
                if (ndone < 3) dones[ndone] = off;
                ndone++;
            end
            if (!tx_busy[0]) busy_low = off;
            if (fifo_empty[0] && empty_at < 0) empty_at = off;
            tick();
            off++;
        end
        expect_eq("b2b_done_count", ndone, 3);
        expect_eq("b2b_done0", dones[0], 109);
        expect_eq("b2b_done1", dones[1], 219);
        expect_eq("b2b_done2", dones[2], 329);
        expect_eq("b2b_busy_fall", busy_low, 330);
        expect_eq("b2b_empty_rise", empty_at, 220);
        $display("b2b u0: dones %0d/%0d/%0d busy low at %0d", dones[0], dones[1], dones[2], busy_low);

        for (int k = 1; k <= 6; k++) push(3, k);
        expect_eq("ovf_flag", int'(overflow[3]), 1);
        expect_eq("ovf_full", int'(fifo_full[3]), 1);
        c = 0; ndone = 0;
        while ((tx_busy[3] || !fifo_empty[3]) && c < 1000) begin
            if (tx_done[3]) ndone++;
            tick();
            c++;
        end
        expect_eq("ovf_frames", ndone, 5);
        expect_eq("ovf_drained", int'(tx_busy[3]), 0);
        $display("overflow u3: %0d frames sent", ndone);

        push(0, 'hA5);
        push(0, 'h5A);
        wait_start(0, "rst_pre");
        repeat (30) tick();
        rst = 1'b1;
        tick();
        expect_eq("midrst_tx", int'(tx[0]), 1);
        expect_eq("midrst_busy", int'(tx_busy[0]), 0);
        expect_eq("midrst_done", int'(tx_done[0]), 0);
        expect_eq("midrst_empty", int'(fifo_empty[0]), 1);
        expect_eq("midrst_ovf_u3", int'(overflow[3]), 0);
        expect_eq("midrst_led_u3", int'(led[3]), 0);
        rst = 1'b0;
        repeat (2) tick();
        push(0, 'h3C);
        check_frame(0, '{0,0,0,1,1,1,1,0,0,0,1,1}, 11, "3c_after_rst", 1'b0);

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
